// File: rtl/h264_seq_pkg.sv
// Shared types and helpers for the H.264 pipeline enable sequencer.
package h264_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    TAIL
  } seq_state_t;

  // Start-to-start period at default parameters with a held start request.
  localparam int unsigned DefaultFramePeriod = (3 + 1) * 1 + 3 + 1;

  function automatic int unsigned step_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/h264_seq_counter.sv
// Wrapping modulo-MAX counter with clear, hold and terminal-count flag.
module h264_seq_counter
  import h264_seq_pkg::*;
#(
  parameter int unsigned MAX = 1,
  localparam int unsigned W = step_w(MAX)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clear,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         term
);

  assign term = (count == W'(MAX - 1));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold && inc) begin
      count <= term ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/h264_pipeline_sequencer.sv
// Frame-level enable sequencer: feed enable plus a one-hot stage walk, then a drain tail.
module h264_pipeline_sequencer
  import h264_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned TAIL_CYCLES = 3,
  parameter int unsigned OVERLAP     = 0,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic                   STALL,
  input  logic                   ABORT,
  output logic                   start_ack,
  output logic                   en_feed,
  output logic [NUM_STAGES-1:0]  en_stage,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int unsigned SubW    = step_w(STEP_CYCLES);
  localparam int unsigned StepW   = step_w(NUM_STAGES + 1);
  localparam int unsigned TailMax = (TAIL_CYCLES == 0) ? 1 : TAIL_CYCLES;
  localparam int unsigned TailW   = step_w(TailMax);

  seq_state_t       state_q;
  logic [SubW-1:0]  sub_q;
  logic [StepW-1:0] step_q;
  logic [TailW-1:0] tail_q;
  logic             sub_term, step_term, tail_term;
  logic             st_idle, st_active, st_tail;
  logic             go, last_active, complete;

  assign st_idle   = (state_q == IDLE);
  assign st_active = (state_q == ACTIVE);
  assign st_tail   = (state_q == TAIL);

  // STALL and ABORT both suppress every pulse/enable in the cycle they are seen.
  assign go          = !STALL && !ABORT;
  assign last_active = st_active && sub_term && step_term;
  assign complete    = (TAIL_CYCLES == 0) ? last_active : (st_tail && tail_term);

  // Counters self-wrap on terminal, so an overlapped restart finds them at zero.
  h264_seq_counter #(
    .MAX (STEP_CYCLES)
  ) u_sub (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (ABORT || !st_active),
    .inc   (1'b1),
    .hold  (STALL),
    .count (sub_q),
    .term  (sub_term)
  );

  h264_seq_counter #(
    .MAX (NUM_STAGES + 1)
  ) u_step (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (ABORT || !st_active),
    .inc   (sub_term),
    .hold  (STALL),
    .count (step_q),
    .term  (step_term)
  );

  h264_seq_counter #(
    .MAX (TailMax)
  ) u_tail (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (ABORT || !st_tail),
    .inc   (1'b1),
    .hold  (STALL),
    .count (tail_q),
    .term  (tail_term)
  );

  logic unused_cnt;
  assign unused_cnt = ^{sub_q, tail_q};

  always_comb begin
    start_ack = ENABLE && go && (st_idle || ((OVERLAP != 0) && complete));
    done      = complete && go;
    en_feed   = st_active && go;
    busy      = st_active || st_tail;
    en_stage  = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (st_active && go && (step_q == StepW'(i + 1))) begin
        en_stage[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      frame_count <= '0;
    end else begin
      if (done) begin
        frame_count <= frame_count + FRAME_CNT_W'(1);
      end
      if (ABORT) begin
        state_q <= IDLE;
      end else if (!STALL) begin
        unique case (state_q)
          IDLE: begin
            if (ENABLE) state_q <= ACTIVE;
          end
          ACTIVE: begin
            if (last_active) begin
              if (TAIL_CYCLES != 0) state_q <= TAIL;
              else                  state_q <= start_ack ? ACTIVE : IDLE;
            end
          end
          TAIL: begin
            if (tail_term) state_q <= start_ack ? ACTIVE : IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_h264_pipeline_sequencer.sv
// Directed bench: default, long-step/no-tail and overlap sequencers on a shared clock and reset.
module tb_h264_pipeline_sequencer;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic       d_en, d_st, d_ab, d_ack, d_feed, d_busy, d_done;
  logic [2:0] d_stage;
  logic [7:0] d_fc;
  logic       l_en, l_st, l_ab, l_ack, l_feed, l_busy, l_done;
  logic [3:0] l_stage;
  logic [7:0] l_fc;
  logic       o_en, o_st, o_ab, o_ack, o_feed, o_busy, o_done;
  logic [2:0] o_stage;
  logic [7:0] o_fc;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] T1Stage [8]    = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0};
  localparam logic [2:0] StallStage [11] =
    '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0};
  localparam logic [3:0] LongStage [11] =
    '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8};

  h264_pipeline_sequencer u_def (
    .CLK (CLK), .RESET (RESET), .ENABLE (d_en), .STALL (d_st), .ABORT (d_ab),
    .start_ack (d_ack), .en_feed (d_feed), .en_stage (d_stage), .busy (d_busy),
    .done (d_done), .frame_count (d_fc)
  );

  h264_pipeline_sequencer #(
    .NUM_STAGES (4), .STEP_CYCLES (2), .TAIL_CYCLES (0)
  ) u_long (
    .CLK (CLK), .RESET (RESET), .ENABLE (l_en), .STALL (l_st), .ABORT (l_ab),
    .start_ack (l_ack), .en_feed (l_feed), .en_stage (l_stage), .busy (l_busy),
    .done (l_done), .frame_count (l_fc)
  );

  h264_pipeline_sequencer #(
    .OVERLAP (1)
  ) u_ovl (
    .CLK (CLK), .RESET (RESET), .ENABLE (o_en), .STALL (o_st), .ABORT (o_ab),
    .start_ack (o_ack), .en_feed (o_feed), .en_stage (o_stage), .busy (o_busy),
    .done (o_done), .frame_count (o_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    {d_en, d_st, d_ab, l_en, l_st, l_ab, o_en, o_st, o_ab} = '0;
    next();
    next();
    #1;
    chk("rst_d_busy", d_busy, 0);
    chk("rst_d_fc", d_fc, 0);
    chk("rst_d_feed", d_feed, 0);
    chk("rst_d_stage", d_stage, 0);
    chk("rst_l_busy", l_busy, 0);
    chk("rst_o_fc", o_fc, 0);
    RESET = 1'b1;

    // Single frame at defaults.
    next(); d_en = 1'b1; #1;
    chk("t1_ack0", d_ack, 1);
    chk("t1_busy0", d_busy, 0);
    for (int c = 1; c <= 7; c++) begin
      next(); d_en = 1'b0; #1;
      chk($sformatf("t1_feed_c%0d", c), d_feed, (c <= 4) ? 1 : 0);
      chk($sformatf("t1_stage_c%0d", c), d_stage, T1Stage[c]);
      chk($sformatf("t1_busy_c%0d", c), d_busy, 1);
      chk($sformatf("t1_done_c%0d", c), d_done, (c == 7) ? 1 : 0);
      chk($sformatf("t1_ack_c%0d", c), d_ack, 0);
    end
    next(); #1;
    chk("t1_fc", d_fc, 1);
    chk("t1_idle_busy", d_busy, 0);

    // Three-cycle stall while stage 2 is due.
    next(); d_en = 1'b1; #1;
    chk("t3_ack0", d_ack, 1);
    for (int c = 1; c <= 10; c++) begin
      next(); d_en = 1'b0; d_st = (c >= 3 && c <= 5); #1;
      chk($sformatf("t3_feed_c%0d", c), d_feed, (c <= 2 || c == 6 || c == 7) ? 1 : 0);
      chk($sformatf("t3_stage_c%0d", c), d_stage, StallStage[c]);
      chk($sformatf("t3_busy_c%0d", c), d_busy, 1);
      chk($sformatf("t3_done_c%0d", c), d_done, (c == 10) ? 1 : 0);
    end
    next(); d_st = 1'b0; #1;
    chk("t3_fc", d_fc, 2);
    chk("t3_idle_busy", d_busy, 0);

    // Abort at step 1, aborted start in IDLE, then a clean restart.
    next(); d_en = 1'b1; #1;
    chk("t4_ack0", d_ack, 1);
    next(); d_en = 1'b0; #1;
    chk("t4_feed1", d_feed, 1);
    next(); d_ab = 1'b1; #1;
    chk("t4_abort_feed", d_feed, 0);
    chk("t4_abort_stage", d_stage, 0);
    chk("t4_abort_done", d_done, 0);
    chk("t4_abort_busy", d_busy, 1);
    next(); d_en = 1'b1; #1;
    chk("t4_idle_busy", d_busy, 0);
    chk("t4_abort_noack", d_ack, 0);
    chk("t4_fc_kept", d_fc, 2);
    next(); d_ab = 1'b0; #1;
    chk("t4_restart_ack", d_ack, 1);
    next(); d_en = 1'b0; #1;
    chk("t4_restart_feed", d_feed, 1);
    chk("t4_restart_stage0", d_stage, 0);
    next(); #1;
    chk("t4_restart_stage1", d_stage, 1);
    repeat (4) next();
    next(); #1;
    chk("t4_done", d_done, 1);
    next(); #1;
    chk("t4_fc", d_fc, 3);

    // Four stages held two cycles each, no tail.
    next(); l_en = 1'b1; #1;
    chk("t2_ack0", l_ack, 1);
    for (int c = 1; c <= 10; c++) begin
      next(); l_en = 1'b0; #1;
      chk($sformatf("t2_feed_c%0d", c), l_feed, 1);
      chk($sformatf("t2_stage_c%0d", c), l_stage, LongStage[c]);
      chk($sformatf("t2_done_c%0d", c), l_done, (c == 10) ? 1 : 0);
    end
    next(); #1;
    chk("t2_after_feed", l_feed, 0);
    chk("t2_after_busy", l_busy, 0);
    chk("t2_fc", l_fc, 1);

    // Held start: overlap period 7 versus 8 without overlap.
    next(); d_en = 1'b1; o_en = 1'b1; #1;
    chk("t5_o_ack0", o_ack, 1);
    chk("t5_d_ack0", d_ack, 1);
    repeat (6) next();
    next(); #1;
    chk("t5_o_done7", o_done, 1);
    chk("t5_o_ack7", o_ack, 1);
    chk("t5_d_done7", d_done, 1);
    chk("t5_d_ack7", d_ack, 0);
    next(); #1;
    chk("t5_o_feed8", o_feed, 1);
    chk("t5_o_stage8", o_stage, 0);
    chk("t5_o_ack8", o_ack, 0);
    chk("t5_d_ack8", d_ack, 1);
    chk("t5_d_busy8", d_busy, 0);
    repeat (5) next();
    next(); #1;
    chk("t5_o_done14", o_done, 1);
    chk("t5_o_ack14", o_ack, 1);
    chk("t5_d_done14", d_done, 0);
    next(); d_en = 1'b0; o_en = 1'b0; #1;
    chk("t5_d_done15", d_done, 1);
    chk("t5_o_fc", o_fc, 2);
    repeat (8) next();
    chk("t5_d_fc", d_fc, 5);
    RESET = 1'b0;
    next(); RESET = 1'b1; #1;
    chk("t5_rst_o_busy", o_busy, 0);

    // Reset in the middle of the tail: no done, counter cleared.
    next(); d_en = 1'b1; #1;
    chk("t6_ack0", d_ack, 1);
    next(); d_en = 1'b0;
    repeat (4) next();
    #1;
    chk("t6_tail_busy", d_busy, 1);
    chk("t6_tail_feed", d_feed, 0);
    RESET = 1'b0;
    next(); #1;
    chk("t6_rst_busy", d_busy, 0);
    chk("t6_rst_done", d_done, 0);
    chk("t6_rst_fc", d_fc, 0);
    chk("t6_rst_ack", d_ack, 0);
    RESET = 1'b1;
    next(); #1;
    chk("t6_post_done", d_done, 0);
    chk("t6_post_busy", d_busy, 0);

    // Run 255 frames, then one more wraps the counter to zero.
    for (int i = 0; i < 255; i++) begin
      next(); d_en = 1'b1;
      next(); d_en = 1'b0;
      repeat (6) next();
    end
    next(); d_en = 1'b1; #1;
    chk("t6_fc255", d_fc, 255);
    chk("t6_wrap_ack", d_ack, 1);
    next(); d_en = 1'b0;
    repeat (5) next();
    next(); #1;
    chk("t6_wrap_done", d_done, 1);
    chk("t6_wrap_fc_hold", d_fc, 255);
    next(); #1;
    chk("t6_wrap_fc0", d_fc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
